// File: rtl/mem_arb_pkg.sv
// Shared types and defaults for the two-requester memory arbiter.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        OWN_I = 2'd1,
        OWN_D = 2'd2
    } arb_state_t;

    typedef enum logic {
        OWNER_I = 1'b0,
        OWNER_D = 1'b1
    } owner_t;

    localparam int TIMEOUT_DEF = 16;
    localparam int WDOG_W      = 5;

endpackage

// File: rtl/arb_wdog.sv
// Ownership watchdog: counts owned cycles, saturates, flags expiry.
module arb_wdog
    import mem_arb_pkg::*;
#(
    parameter int TIMEOUT = TIMEOUT_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic expired
);

    localparam logic [WDOG_W-1:0] LIMIT = WDOG_W'(TIMEOUT - 1);

    logic [WDOG_W-1:0] count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (en && count != '1) begin
            count <= count + 1'b1;
        end
    end

    assign expired = (count >= LIMIT);

endmodule

// File: rtl/mem_arbiter.sv
// Round-robin I/D cache memory arbiter with watchdog and strobe checks.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int TIMEOUT = TIMEOUT_DEF,
    parameter int AW      = 16,
    parameter int DW      = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          i_req,
    input  logic          d_req,
    input  logic          i_rd,
    input  logic          i_wr,
    input  logic          d_rd,
    input  logic          d_wr,
    input  logic [AW-1:0] i_addr,
    input  logic [AW-1:0] d_addr,
    input  logic [DW-1:0] i_data,
    input  logic [DW-1:0] d_data,
    input  logic          i_release,
    input  logic          d_release,
    output logic          i_gnt,
    output logic          d_gnt,
    output logic          mem_rd,
    output logic          mem_wr,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_data_in,
    output logic          err
);

    arb_state_t state, next_state;
    owner_t     last_owner;

    logic          own_req, own_rd, own_wr, own_rel;
    logic [AW-1:0] own_addr;
    logic [DW-1:0] own_data;
    logic          owned, done, illegal, expired, timeout;

    always_comb begin
        own_req  = 1'b0;
        own_rd   = 1'b0;
        own_wr   = 1'b0;
        own_rel  = 1'b0;
        own_addr = '0;
        own_data = '0;
        unique case (state)
            OWN_I: begin
                own_req  = i_req;
                own_rd   = i_rd;
                own_wr   = i_wr;
                own_rel  = i_release;
                own_addr = i_addr;
                own_data = i_data;
            end
            OWN_D: begin
                own_req  = d_req;
                own_rd   = d_rd;
                own_wr   = d_wr;
                own_rel  = d_release;
                own_addr = d_addr;
                own_data = d_data;
            end
            default: ;
        endcase
    end

    assign owned   = (state != IDLE);
    assign done    = owned && (own_rel || !own_req);
    assign illegal = owned && own_rd && own_wr;
    // Release beats a coincident timeout, so no error in that case.
    assign timeout = owned && expired && !done;

    always_comb begin
        next_state = state;
        unique case (state)
            IDLE: begin
                if (i_req && d_req) begin
                    next_state = (last_owner == OWNER_D) ? OWN_I : OWN_D;
                end else if (i_req) begin
                    next_state = OWN_I;
                end else if (d_req) begin
                    next_state = OWN_D;
                end
            end
            OWN_I, OWN_D: begin
                if (done || expired) begin
                    next_state = IDLE;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            last_owner <= OWNER_D;
            err        <= 1'b0;
        end else begin
            state <= next_state;
            err   <= illegal || timeout;
            if (state == IDLE && next_state == OWN_I) begin
                last_owner <= OWNER_I;
            end else if (state == IDLE && next_state == OWN_D) begin
                last_owner <= OWNER_D;
            end
        end
    end

    arb_wdog #(
        .TIMEOUT(TIMEOUT)
    ) u_wdog (
        .clk    (clk),
        .rst    (rst),
        .clr    (!owned),
        .en     (owned),
        .expired(expired)
    );

    assign i_gnt       = (state == OWN_I);
    assign d_gnt       = (state == OWN_D);
    assign mem_rd      = own_rd && !own_wr;
    assign mem_wr      = own_wr && !own_rd;
    assign mem_addr    = own_addr;
    assign mem_data_in = own_data;

endmodule

// File: tb/tb_mem_arbiter.sv
// Vector table plus corner sequences for mem_arbiter.
module tb_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        i_req, d_req, i_rd, i_wr, d_rd, d_wr;
    logic [15:0] i_addr, d_addr, i_data, d_data;
    logic        i_release, d_release;
    logic        i_gnt, d_gnt, mem_rd, mem_wr, err;
    logic [15:0] mem_addr, mem_data_in;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [7:0]  ctl;
        logic [15:0] ia, idat, da, ddat;
        logic [36:0] exp_o;
    } vec_t;

    vec_t        vecs[14];
    logic [36:0] sb[$];

    always #5 clk = ~clk;

    mem_arbiter dut (
        .clk        (clk),
        .rst        (rst),
        .i_req      (i_req),
        .d_req      (d_req),
        .i_rd       (i_rd),
        .i_wr       (i_wr),
        .d_rd       (d_rd),
        .d_wr       (d_wr),
        .i_addr     (i_addr),
        .d_addr     (d_addr),
        .i_data     (i_data),
        .d_data     (d_data),
        .i_release  (i_release),
        .d_release  (d_release),
        .i_gnt      (i_gnt),
        .d_gnt      (d_gnt),
        .mem_rd     (mem_rd),
        .mem_wr     (mem_wr),
        .mem_addr   (mem_addr),
        .mem_data_in(mem_data_in),
        .err        (err)
    );

    // ctl = {i_req,d_req,i_rd,i_wr,d_rd,d_wr,i_release,d_release}
    // eo  = {i_gnt,d_gnt,mem_rd,mem_wr,err}
    function automatic vec_t mk(
        input logic [7:0]  ctl,
        input logic [15:0] ia, idat, da, ddat,
        input logic [4:0]  eo,
        input logic [15:0] eaddr, edata
    );
        vec_t v;
        v.ctl   = ctl;
        v.ia    = ia;
        v.idat  = idat;
        v.da    = da;
        v.ddat  = ddat;
        v.exp_o = {eo, eaddr, edata};
        return v;
    endfunction

    function automatic logic [36:0] outs();
        return {i_gnt, d_gnt, mem_rd, mem_wr, err, mem_addr, mem_data_in};
    endfunction

    task automatic check(input string name, input logic [63:0] got,
                         input logic [63:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got=%0h want=%0h", name, got, want);
        end
    endtask

    task automatic idle_inputs();
        i_req = 0; d_req = 0; i_rd = 0; i_wr = 0; d_rd = 0; d_wr = 0;
        i_addr = 0; d_addr = 0; i_data = 0; d_data = 0;
        i_release = 0; d_release = 0;
    endtask

    task automatic do_reset();
        idle_inputs();
        @(negedge clk);
        rst = 1'b1;
        #2;
        check("reset_outs", 64'(outs()), 64'd0);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic apply(input vec_t v);
        {i_req, d_req, i_rd, i_wr, d_rd, d_wr, i_release, d_release} = v.ctl;
        i_addr = v.ia;
        i_data = v.idat;
        d_addr = v.da;
        d_data = v.ddat;
    endtask

    initial begin
        int owned;
        logic [36:0] want;

        rst = 1'b1;
        idle_inputs();

        vecs[0]  = mk(8'b1010_0000, 16'h1234, 16'hAAAA, 16'h0, 16'h0,
                      5'b00000, 16'h0, 16'h0);
        vecs[1]  = mk(8'b1010_0000, 16'h1234, 16'hAAAA, 16'h0, 16'h0,
                      5'b10100, 16'h1234, 16'hAAAA);
        vecs[2]  = mk(8'b1101_1000, 16'h0010, 16'h5555, 16'hBEEF, 16'h1111,
                      5'b10010, 16'h0010, 16'h5555);
        vecs[3]  = mk(8'b1111_0000, 16'h0020, 16'h5555, 16'hBEEF, 16'h1111,
                      5'b10000, 16'h0020, 16'h5555);
        vecs[4]  = mk(8'b1100_0001, 16'h0030, 16'h5555, 16'h0, 16'h0,
                      5'b10001, 16'h0030, 16'h5555);
        vecs[5]  = mk(8'b1100_0010, 16'h0030, 16'h5555, 16'h0, 16'h0,
                      5'b10000, 16'h0030, 16'h5555);
        vecs[6]  = mk(8'b0100_0000, 16'h0, 16'h0, 16'h4444, 16'h7777,
                      5'b00000, 16'h0, 16'h0);
        vecs[7]  = mk(8'b0100_1000, 16'h0, 16'h0, 16'h4444, 16'h7777,
                      5'b01100, 16'h4444, 16'h7777);
        vecs[8]  = mk(8'b0000_0000, 16'h0, 16'h0, 16'h4445, 16'h7777,
                      5'b01000, 16'h4445, 16'h7777);
        vecs[9]  = mk(8'b1100_0000, 16'h0040, 16'h0001, 16'h0, 16'h0,
                      5'b00000, 16'h0, 16'h0);
        vecs[10] = mk(8'b1100_0000, 16'h0040, 16'h0001, 16'h0, 16'h0,
                      5'b10000, 16'h0040, 16'h0001);
        vecs[11] = mk(8'b1100_0010, 16'h0040, 16'h0001, 16'h0, 16'h0,
                      5'b10000, 16'h0040, 16'h0001);
        vecs[12] = mk(8'b1100_0000, 16'h0, 16'h0, 16'h0050, 16'h0002,
                      5'b00000, 16'h0, 16'h0);
        vecs[13] = mk(8'b1100_0000, 16'h0, 16'h0, 16'h0050, 16'h0002,
                      5'b01000, 16'h0050, 16'h0002);

        do_reset();

        foreach (vecs[k]) begin
            @(negedge clk);
            apply(vecs[k]);
            sb.push_back(vecs[k].exp_o);
            #2;
            want = sb.pop_front();
            check($sformatf("vec%0d", k), 64'(outs()), 64'(want));
        end

        // Watchdog expiry with a D owner that never releases.
        do_reset();
        owned = 0;
        d_req = 1'b1;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            #2;
            if (d_gnt) owned++;
            else if (owned > 0) break;
        end
        check("timeout_owned_cycles", 64'(owned), 64'd16);
        check("timeout_err_pulse", 64'(err), 64'd1);
        check("timeout_gnt_drop", 64'(d_gnt), 64'd0);
        @(negedge clk);
        #2;
        check("timeout_err_clear", 64'(err), 64'd0);
        check("timeout_regrant", 64'(d_gnt), 64'd1);

        // Release on the final allowed cycle beats the timeout.
        do_reset();
        owned = 0;
        d_req = 1'b1;
        for (int c = 0; c < 40 && owned < 16; c++) begin
            @(negedge clk);
            #2;
            if (d_gnt) owned++;
        end
        check("relto_owned", 64'(owned), 64'd16);
        d_release = 1'b1;
        @(negedge clk);
        d_release = 1'b0;
        d_req = 1'b0;
        #2;
        check("relto_gnt_drop", 64'(d_gnt), 64'd0);
        check("relto_no_err", 64'(err), 64'd0);

        // Asynchronous reset in the middle of an I write burst.
        do_reset();
        i_req = 1'b1;
        i_wr = 1'b1;
        i_addr = 16'h0060;
        @(negedge clk);
        @(negedge clk);
        #2;
        check("burst_wr_on", 64'({i_gnt, mem_wr}), 64'b11);
        #1;
        rst = 1'b1;
        #1;
        check("async_rst_drop", 64'({i_gnt, mem_wr, mem_addr}), 64'd0);
        d_req = 1'b1;
        i_wr = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        #2;
        check("post_rst_tie", 64'({i_gnt, d_gnt}), 64'b10);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
